uart_word_bridge: RTL and testbench

Parametrised word/byte bridge between a system-side word interface and the byte-level UART transmitter and receiver handshakes. On the TX side, a word FIFO of configurable depth is serialised into bytes with a selectable byte order and no inter-word bubble. On the RX side, received bytes are packed into words; on a line-idle event a trailing partial word is either flushed zero-padded, with a byte count, or discarded. It replaces the fixed 32-bit, fixed-order word path in the UART top level.

---
 rtl/uart_word_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_uart_word_bridge.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_bridge.sv
// uart_word_bridge: word FIFO + byte serialiser toward the UART transmitter,
// and byte-to-word packer (with idle flush/discard) from the UART receiver.
module uart_word_bridge #(
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter bit          MSB_FIRST      = 1'b1,
  parameter bit          RX_PAD_PARTIAL = 1'b1
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic [8*WORD_BYTES-1:0]       tx_word,
  input  logic                          tx_word_valid,
  output logic                          tx_word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_level,
  output logic [7:0]                    tx_data,
  output logic                          tx_data_valid,
  input  logic                          tx_data_ready,
  output logic                          tx_busy,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_data_valid,
  input  logic                          rx_frame_idle,
  output logic [8*WORD_BYTES-1:0]       rx_word,
  output logic                          rx_word_valid,
  output logic [3:0]                    rx_word_bytes,
  output logic                          rx_word_partial,
  output logic                          rx_discard
);

  localparam int unsigned W   = 8 * WORD_BYTES;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned BIW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BIW-1:0] LAST_IDX = BIW'(WORD_BYTES - 1);
  localparam logic [AW:0]    DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } ser_state_e;

  ser_state_e     state_q, state_d;
  logic [W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    level_d;
  logic [W-1:0]   shreg;
  logic [BIW-1:0] byte_idx;
  logic           push, pop_c, adv_c, hs, last_byte, fifo_ne;

  assign push      = tx_word_valid && tx_word_ready;
  assign fifo_ne   = (tx_fifo_level != '0);
  assign hs        = tx_data_valid && tx_data_ready;
  assign last_byte = (byte_idx == LAST_IDX);
  assign tx_data   = (MSB_FIRST != 1'b0) ? shreg[W-1 -: 8] : shreg[7:0];

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    level_d = tx_fifo_level;
    if (push && !pop_c) begin
      level_d = tx_fifo_level + 1'b1;
    end else if (!push && pop_c) begin
      level_d = tx_fifo_level - 1'b1;
    end
  end

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= tx_word;
    end
  end

  // FIFO pointers, level and registered status flags
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tx_fifo_level <= '0;
      tx_word_ready <= 1'b1;
      tx_busy       <= 1'b0;
      tx_data_valid <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_c) rd_ptr <= rd_ptr + 1'b1;
      tx_fifo_level <= level_d;
      tx_word_ready <= (level_d < DEPTH);
      tx_busy       <= (level_d != '0) || (state_d != S_IDLE);
      tx_data_valid <= (state_d == S_SEND);
    end
  end

  // Serialiser state register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Serialiser next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fifo_ne) state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND:  if (hs && last_byte && !fifo_ne) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Serialiser controls: pop on load or on a back-to-back reload, else advance
  always_comb begin
    pop_c = 1'b0;
    adv_c = 1'b0;
    case (state_q)
      S_LOAD: pop_c = 1'b1;
      S_SEND: begin
        if (hs) begin
          if (!last_byte)   adv_c = 1'b1;
          else if (fifo_ne) pop_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Shift register: the outgoing byte always sits in the leading lane
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (pop_c) begin
      shreg    <= fifo_mem[rd_ptr];
      byte_idx <= '0;
    end else if (adv_c) begin
      shreg    <= (MSB_FIRST != 1'b0) ? (shreg << 8) : (shreg >> 8);
      byte_idx <= byte_idx + 1'b1;
    end
  end

  logic [BIW-1:0] rx_idx_q, rx_idx_d, lane;
  logic [W-1:0]   asm_q, asm_d, emit_word;
  logic [3:0]     emit_bytes;
  logic           emit_c, emit_partial, discard_c, full_c;

  // RX packing: byte first, then the idle rule applied to the result
  always_comb begin
    rx_idx_d     = rx_idx_q;
    asm_d        = asm_q;
    emit_c       = 1'b0;
    emit_word    = asm_q;
    emit_bytes   = '0;
    emit_partial = 1'b0;
    discard_c    = 1'b0;
    full_c       = 1'b0;
    lane         = (MSB_FIRST != 1'b0) ? (LAST_IDX - rx_idx_q) : rx_idx_q;
    if (rx_data_valid) begin
      asm_d[{lane, 3'b000} +: 8] = rx_data;
      if (rx_idx_q == LAST_IDX) begin
        emit_c     = 1'b1;
        full_c     = 1'b1;
        emit_word  = asm_d;
        emit_bytes = 4'(WORD_BYTES);
        rx_idx_d   = '0;
        asm_d      = '0;
      end else begin
        rx_idx_d = rx_idx_q + 1'b1;
      end
    end
    if (rx_frame_idle && !full_c && (rx_idx_d != '0)) begin
      if (RX_PAD_PARTIAL != 1'b0) begin
        emit_c       = 1'b1;
        emit_word    = asm_d;
        emit_bytes   = 4'(rx_idx_d);
        emit_partial = 1'b1;
      end else begin
        discard_c = 1'b1;
      end
      rx_idx_d = '0;
      asm_d    = '0;
    end
  end

  // RX assembly state and held word outputs
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_idx_q        <= '0;
      asm_q           <= '0;
      rx_word         <= '0;
      rx_word_valid   <= 1'b0;
      rx_word_bytes   <= '0;
      rx_word_partial <= 1'b0;
      rx_discard      <= 1'b0;
    end else begin
      rx_idx_q      <= rx_idx_d;
      asm_q         <= asm_d;
      rx_word_valid <= emit_c;
      rx_discard    <= discard_c;
      if (emit_c) begin
        rx_word         <= emit_word;
        rx_word_bytes   <= emit_bytes;
        rx_word_partial <= emit_partial;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench: instance a is MSB-first/pad, instance b is LSB-first/discard,
// both driven by the same stimulus.
module tb_uart_word_bridge;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tx_word = '0;
  logic        tx_word_valid = 1'b0;
  logic        tx_data_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_data_valid = 1'b0;
  logic        rx_frame_idle = 1'b0;

  logic        a_tx_word_ready, a_tx_data_valid, a_tx_busy;
  logic [3:0]  a_tx_fifo_level, a_rx_word_bytes;
  logic [7:0]  a_tx_data;
  logic [31:0] a_rx_word;
  logic        a_rx_word_valid, a_rx_word_partial, a_rx_discard;
  logic        b_tx_word_ready, b_tx_data_valid, b_tx_busy;
  logic [3:0]  b_tx_fifo_level, b_rx_word_bytes;
  logic [7:0]  b_tx_data;
  logic [31:0] b_rx_word;
  logic        b_rx_word_valid, b_rx_word_partial, b_rx_discard;

  int n_cmp = 0;
  int n_err = 0;

  uart_word_bridge #(.WORD_BYTES(4), .FIFO_DEPTH(8), .MSB_FIRST(1'b1), .RX_PAD_PARTIAL(1'b1)) u_dut_a (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .tx_word(tx_word), .tx_word_valid(tx_word_valid), .tx_word_ready(a_tx_word_ready),
    .tx_fifo_level(a_tx_fifo_level), .tx_data(a_tx_data), .tx_data_valid(a_tx_data_valid),
    .tx_data_ready(tx_data_ready), .tx_busy(a_tx_busy),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_frame_idle(rx_frame_idle),
    .rx_word(a_rx_word), .rx_word_valid(a_rx_word_valid), .rx_word_bytes(a_rx_word_bytes),
    .rx_word_partial(a_rx_word_partial), .rx_discard(a_rx_discard)
  );

  uart_word_bridge #(.WORD_BYTES(4), .FIFO_DEPTH(8), .MSB_FIRST(1'b0), .RX_PAD_PARTIAL(1'b0)) u_dut_b (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .tx_word(tx_word), .tx_word_valid(tx_word_valid), .tx_word_ready(b_tx_word_ready),
    .tx_fifo_level(b_tx_fifo_level), .tx_data(b_tx_data), .tx_data_valid(b_tx_data_valid),
    .tx_data_ready(tx_data_ready), .tx_busy(b_tx_busy),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_frame_idle(rx_frame_idle),
    .rx_word(b_rx_word), .rx_word_valid(b_rx_word_valid), .rx_word_bytes(b_rx_word_bytes),
    .rx_word_partial(b_rx_word_partial), .rx_discard(b_rx_discard)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    tx_word = w;
    tx_word_valid = 1'b1;
    while (!a_tx_word_ready && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) check("push_timeout", a_tx_word_ready, 1);
    step();
    tx_word_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic idle);
    rx_data = b;
    rx_data_valid = 1'b1;
    rx_frame_idle = idle;
    step();
    rx_data_valid = 1'b0;
    rx_frame_idle = 1'b0;
  endtask

  task automatic idle_pulse();
    rx_frame_idle = 1'b1;
    step();
    rx_frame_idle = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wv;
    logic        acc;
    logic [7:0]  ea, eb;

    repeat (2) step();
    check("rst_ready", a_tx_word_ready, 1);
    check("rst_level", a_tx_fifo_level, 0);
    check("rst_txdata", a_tx_data, 0);
    check("rst_txvalid", a_tx_data_valid, 0);
    check("rst_busy", a_tx_busy, 0);
    check("rst_rxword", a_rx_word, 0);
    check("rst_rxvalid", a_rx_word_valid, 0);
    check("rst_rxbytes", a_rx_word_bytes, 0);
    check("rst_rxpartial", a_rx_word_partial, 0);
    check("rst_discard_b", b_rx_discard, 0);
    rst_n = 1'b1;
    step();

    // TX byte order, no backpressure
    tx_data_ready = 1'b1;
    wv = 32'h11223344;
    push(wv);
    check("tx_level_after_push", a_tx_fifo_level, 1);
    check("tx_busy_after_push", a_tx_busy, 1);
    check("tx_valid_n", a_tx_data_valid, 0);
    step();
    check("tx_valid_load", a_tx_data_valid, 0);
    step();
    for (int j = 0; j < 4; j++) begin
      ea = wv[31 - 8*j -: 8];
      eb = wv[8*j +: 8];
      check("tx_order_valid", a_tx_data_valid, 1);
      check("tx_order_msb", a_tx_data, ea);
      check("tx_order_lsb", b_tx_data, eb);
      check("tx_order_busy", a_tx_busy, 1);
      step();
    end
    check("tx_order_done_valid", a_tx_data_valid, 0);
    check("tx_order_done_busy_a", a_tx_busy, 0);
    check("tx_order_done_busy_b", b_tx_busy, 0);

    // FIFO fill under backpressure
    tx_data_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(32'(i));
    check("full_level_a", a_tx_fifo_level, 8);
    check("full_level_b", b_tx_fifo_level, 8);
    check("full_ready", a_tx_word_ready, 0);
    check("full_valid", a_tx_data_valid, 1);
    tx_word = 32'd9;
    tx_word_valid = 1'b1;
    repeat (3) step();
    check("stall_level", a_tx_fifo_level, 8);
    check("stall_ready", a_tx_word_ready, 0);
    tx_data_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ea = ((k % 4) == 3) ? 8'(k / 4) : 8'h00;
      eb = ((k % 4) == 0) ? 8'(k / 4) : 8'h00;
      check("drain_valid", a_tx_data_valid, 1);
      check("drain_msb", a_tx_data, ea);
      check("drain_lsb", b_tx_data, eb);
      acc = tx_word_valid && a_tx_word_ready;
      step();
      if (acc) tx_word_valid = 1'b0;
    end
    check("drain_done_valid", a_tx_data_valid, 0);
    check("drain_done_busy", a_tx_busy, 0);
    check("drain_done_level", a_tx_fifo_level, 0);
    check("drain_done_ready", a_tx_word_ready, 1);
    check("drain_word9_taken", tx_word_valid, 0);

    // RX full word
    rx_byte(8'hAA, 1'b0);
    rx_byte(8'hBB, 1'b0);
    rx_byte(8'hCC, 1'b0);
    check("rx_full_early", a_rx_word_valid, 0);
    rx_byte(8'hDD, 1'b0);
    check("rx_full_valid_a", a_rx_word_valid, 1);
    check("rx_full_word_a", a_rx_word, 32'hAABBCCDD);
    check("rx_full_bytes_a", a_rx_word_bytes, 4);
    check("rx_full_partial_a", a_rx_word_partial, 0);
    check("rx_full_valid_b", b_rx_word_valid, 1);
    check("rx_full_word_b", b_rx_word, 32'hDDCCBBAA);
    step();
    check("rx_full_strobe_once", a_rx_word_valid, 0);
    check("rx_full_hold", a_rx_word, 32'hAABBCCDD);

    // Idle with empty assembly does nothing
    idle_pulse();
    check("rx_idle0_valid", a_rx_word_valid, 0);
    check("rx_idle0_discard", b_rx_discard, 0);

    // Partial word then idle
    rx_byte(8'h12, 1'b0);
    rx_byte(8'h34, 1'b0);
    idle_pulse();
    check("rx_part_valid_a", a_rx_word_valid, 1);
    check("rx_part_word_a", a_rx_word, 32'h12340000);
    check("rx_part_bytes_a", a_rx_word_bytes, 2);
    check("rx_part_partial_a", a_rx_word_partial, 1);
    check("rx_part_discard_a", a_rx_discard, 0);
    check("rx_part_valid_b", b_rx_word_valid, 0);
    check("rx_part_discard_b", b_rx_discard, 1);
    check("rx_part_hold_b", b_rx_word, 32'hDDCCBBAA);
    step();
    check("rx_part_discard_once", b_rx_discard, 0);
    check("rx_part_strobe_once", a_rx_word_valid, 0);

    // Idle together with a non-final byte
    rx_byte(8'h56, 1'b0);
    rx_byte(8'h78, 1'b1);
    check("rx_coinc2_word_a", a_rx_word, 32'h56780000);
    check("rx_coinc2_bytes_a", a_rx_word_bytes, 2);
    check("rx_coinc2_discard_b", b_rx_discard, 1);

    // Idle together with the final byte: one full word only
    rx_byte(8'h01, 1'b0);
    rx_byte(8'h02, 1'b0);
    rx_byte(8'h03, 1'b0);
    rx_byte(8'h04, 1'b1);
    check("rx_coinc4_valid_a", a_rx_word_valid, 1);
    check("rx_coinc4_word_a", a_rx_word, 32'h01020304);
    check("rx_coinc4_bytes_a", a_rx_word_bytes, 4);
    check("rx_coinc4_partial_a", a_rx_word_partial, 0);
    check("rx_coinc4_word_b", b_rx_word, 32'h04030201);
    check("rx_coinc4_discard_b", b_rx_discard, 0);
    step();
    check("rx_coinc4_once_a", a_rx_word_valid, 0);
    check("rx_coinc4_once_b", b_rx_word_valid, 0);
    check("rx_coinc4_nodisc_b", b_rx_discard, 0);

    // Asynchronous reset mid-word on both paths
    rx_byte(8'h55, 1'b0);
    rx_byte(8'h66, 1'b0);
    rx_byte(8'h77, 1'b0);
    push(32'hA1B2C3D4);
    repeat (3) step();
    check("rst_mid_byte2_a", a_tx_data, 8'hB2);
    check("rst_mid_byte2_b", b_tx_data, 8'hC3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid_a", a_tx_data_valid, 0);
    check("rst_mid_valid_b", b_tx_data_valid, 0);
    check("rst_mid_level", a_tx_fifo_level, 0);
    check("rst_mid_ready", a_tx_word_ready, 1);
    check("rst_mid_busy", a_tx_busy, 0);
    step();
    check("rst_mid_nodisc_b", b_rx_discard, 0);
    rst_n = 1'b1;
    step();
    rx_byte(8'h01, 1'b0);
    check("rst_rx_idx_cleared", a_rx_word_valid, 0);
    rx_byte(8'h02, 1'b0);
    rx_byte(8'h03, 1'b0);
    rx_byte(8'h04, 1'b0);
    check("rst_rx_valid_a", a_rx_word_valid, 1);
    check("rst_rx_word_a", a_rx_word, 32'h01020304);
    check("rst_rx_word_b", b_rx_word, 32'h04030201);
    check("rst_tx_idle", a_tx_data_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
